frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/cnn_seq_pkg.sv | 22 ++
 rtl/seq_addr_gen.sv | 50 +++++
 rtl/frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// rtl/cnn_seq_pkg.sv - state encoding, default sizes and timeout class for frame_sequencer
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

    localparam int DEF_PIX_W      = 8;
    localparam int DEF_IMG_PIXELS = 784;
    localparam int DEF_NUM_IMG    = 100;
    localparam int DEF_CLASS_W    = 4;
    localparam int DEF_TIMEOUT    = 4095;

    // A timed-out image reports the all-ones class; sliced to CLASS_W at the use site.
    localparam logic [31:0] TIMEOUT_CLASS = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_addr_gen.sv
// rtl/seq_addr_gen.sv - running image-memory address, per-image pixel counter and last-pixel flag
module seq_addr_gen
    import cnn_seq_pkg::*;
#(
    parameter int IMG_PIXELS = DEF_IMG_PIXELS,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_clr,
    input  logic              img_clr,
    input  logic              stream,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              drained
);

    localparam int PCNT_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;

    logic [PCNT_W-1:0] pix_cnt;
    logic              last_pix;

    assign last_pix = (pix_cnt == PCNT_W'(IMG_PIXELS - 1));
    assign rd       = stream && !drained;

    // The address never rewinds between images, so image n starts at n*IMG_PIXELS for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr    <= '0;
            pix_cnt <= '0;
            drained <= 1'b0;
        end else if (run_clr) begin
            addr    <= '0;
            pix_cnt <= '0;
            drained <= 1'b0;
        end else if (img_clr) begin
            pix_cnt <= '0;
            drained <= 1'b0;
        end else if (rd) begin
            addr <= addr + ADDR_W'(1);
            if (last_pix) begin
                pix_cnt <= '0;
                drained <= 1'b1;
            end else begin
                pix_cnt <= pix_cnt + PCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - streams NUM_IMG images to a CNN and reports each decision; SEQ_SCORE_EN enables label scoring
module frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int   PIX_W      = DEF_PIX_W,
    parameter int   IMG_PIXELS = DEF_IMG_PIXELS,
    parameter int   NUM_IMG    = DEF_NUM_IMG,
    parameter int   CLASS_W    = DEF_CLASS_W,
    parameter int   TIMEOUT    = DEF_TIMEOUT,
    localparam int  ADDR_W     = (NUM_IMG * IMG_PIXELS > 1) ? $clog2(NUM_IMG * IMG_PIXELS) : 1,
    localparam int  IDX_W      = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
    localparam int  CNT_W      = $clog2(NUM_IMG + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [PIX_W-1:0]   mem_data,
    input  logic [CLASS_W-1:0] lbl_data,
    output logic [PIX_W-1:0]   pix_out,
    output logic               pix_valid,
    output logic               cnn_clr,
    input  logic [CLASS_W-1:0] cnn_decision,
    input  logic               cnn_valid,
    output logic               res_valid,
    output logic [IDX_W-1:0]   res_idx,
    output logic [CLASS_W-1:0] res_class,
    output logic               res_timeout,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic               busy,
    output logic               done
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    seq_state_t       state, state_nxt;
    logic             run_clr;
    logic             rd;
    logic             drained;
    logic [IDX_W-1:0] img_idx;
    logic [TO_W-1:0]  wait_cnt;
    logic             last_img;
    logic             timeout_hit;

    assign last_img    = (img_idx == IDX_W'(NUM_IMG - 1));
    assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT - 1));

    seq_addr_gen #(
        .IMG_PIXELS (IMG_PIXELS),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .run_clr (run_clr),
        .img_clr (state == S_CLR),
        .stream  (state == S_STREAM),
        .rd      (rd),
        .addr    (mem_addr),
        .drained (drained)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run_clr   = 1'b0;
        cnn_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt = S_CLR;
                    run_clr   = 1'b1;
                end
            end
            S_CLR: begin
                busy      = 1'b1;
                cnn_clr   = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                // drained rises with the last valid pixel, so WAIT starts one cycle later
                if (drained) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnn_valid || timeout_hit) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                state_nxt = last_img ? S_DONE : S_CLR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_rd  = rd;
    assign pix_out = pix_valid ? mem_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid   <= 1'b0;
            img_idx     <= '0;
            wait_cnt    <= '0;
            res_idx     <= '0;
            res_class   <= '0;
            res_timeout <= 1'b0;
        end else begin
            pix_valid <= rd;

            if (run_clr) img_idx <= '0;
            else if (state == S_REPORT && !last_img) img_idx <= img_idx + IDX_W'(1);

            if (state == S_WAIT) wait_cnt <= wait_cnt + TO_W'(1);
            else                 wait_cnt <= '0;

            // A decision arriving on the timeout cycle still counts as a real result.
            if (state == S_WAIT && (cnn_valid || timeout_hit)) begin
                res_idx <= img_idx;
                if (cnn_valid) begin
                    res_class   <= cnn_decision;
                    res_timeout <= 1'b0;
                end else begin
                    res_class   <= TIMEOUT_CLASS[CLASS_W-1:0];
                    res_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_SCORE_EN
    logic [CNT_W-1:0] score;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score <= '0;
        end else if (run_clr) begin
            score <= '0;
        end else if (state == S_REPORT && !res_timeout && res_class == lbl_data &&
                     score != CNT_W'(NUM_IMG)) begin
            score <= score + CNT_W'(1);
        end
    end

    assign correct_cnt = score;
`else
    logic unused_lbl;
    assign unused_lbl  = ^lbl_data;
    assign correct_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer; expectations follow SEQ_SCORE_EN
module tb_frame_sequencer;

    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = 4;
    localparam int NUM_IMG    = 3;
    localparam int CLASS_W    = 4;
    localparam int TIMEOUT    = 8;
    localparam int ADDR_W     = 4;
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 2;

    typedef struct {
        int idx;
        int cls;
        int to;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_main = 1'b0;
    logic               start_noise = 1'b0;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [PIX_W-1:0]   mem_data = '0;
    logic [CLASS_W-1:0] lbl_data = '0;
    logic [PIX_W-1:0]   pix_out;
    logic               pix_valid;
    logic               cnn_clr;
    logic [CLASS_W-1:0] cnn_decision = '0;
    logic               cnn_valid = 1'b0;
    logic               res_valid;
    logic [IDX_W-1:0]   res_idx;
    logic [CLASS_W-1:0] res_class;
    logic               res_timeout;
    logic [CNT_W-1:0]   correct_cnt;
    logic               busy;
    logic               done;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   delay[3];
    int   dec[3];
    int   lbl[3];
    int   addr_q[$];
    int   pix_q[$];
    res_t res_q[$];
    int   res_cyc_q[$];
    int   pix_total = 0;
    int   pix_in_img = 0;
    int   img_str = 0;
    int   clr_cnt = 0;
    int   resp_cyc = -1;
    int   resp_dec = 0;
    int   exp_correct = 0;
    int   last_cls = 0;
    bit   noise_en = 1'b0;

    always #5 clk = ~clk;

    frame_sequencer #(
        .PIX_W      (PIX_W),
        .IMG_PIXELS (IMG_PIXELS),
        .NUM_IMG    (NUM_IMG),
        .CLASS_W    (CLASS_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start_main | start_noise),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .lbl_data     (lbl_data),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .cnn_clr      (cnn_clr),
        .cnn_decision (cnn_decision),
        .cnn_valid    (cnn_valid),
        .res_valid    (res_valid),
        .res_idx      (res_idx),
        .res_class    (res_class),
        .res_timeout  (res_timeout),
        .correct_cnt  (correct_cnt),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [PIX_W-1:0] pix_val(input int a);
        return PIX_W'((a * 37 + 11) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Memory, CNN and label model; samples at negedge, then drives the next cycle's inputs.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            cyc++;
            start_noise = 1'b0;
            if (mem_rd) begin
                if (addr_q.size() == 0) check("mem_rd_extra", 1, 0);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (pix_valid) begin
                if (pix_q.size() == 0) check("pix_extra", 1, 0);
                else check("pix_out", pix_out, pix_q.pop_front());
                pix_total++;
                pix_in_img++;
                if (pix_in_img == IMG_PIXELS) begin
                    pix_in_img = 0;
                    if (img_str < NUM_IMG) begin
                        if (delay[img_str] >= 0) begin
                            resp_cyc = cyc + 1 + delay[img_str];
                            resp_dec = dec[img_str];
                            res_cyc_q.push_back(cyc + 2 + delay[img_str]);
                        end else begin
                            res_cyc_q.push_back(cyc + 1 + TIMEOUT);
                        end
                    end
                    img_str++;
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    check("res_extra", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("res_idx", res_idx, r.idx);
                    check("res_class", res_class, r.cls);
                    check("res_timeout", res_timeout, r.to);
                    if (res_cyc_q.size() == 0) check("res_cycle_missing", 1, 0);
                    else check("res_cycle", cyc, res_cyc_q.pop_front());
                end
            end
            if (cnn_clr) begin
                if (clr_cnt < NUM_IMG) lbl_data = CLASS_W'(lbl[clr_cnt]);
                clr_cnt++;
            end
            mem_data = mem_rd ? pix_val(int'(mem_addr)) : PIX_W'($urandom);
            if (cyc == resp_cyc) begin
                cnn_valid    = 1'b1;
                cnn_decision = CLASS_W'(resp_dec);
            end else if (noise_en && pix_valid && pix_in_img == 1) begin
                cnn_valid    = 1'b1;
                cnn_decision = 4'hE;
                start_noise  = 1'b1;
            end else begin
                cnn_valid    = 1'b0;
                cnn_decision = 4'hE;
            end
        end
    end

    task automatic setup(input int d0, input int d1, input int d2,
                         input int c0, input int c1, input int c2,
                         input int l0, input int l1, input int l2);
        delay[0] = d0; delay[1] = d1; delay[2] = d2;
        dec[0]   = c0; dec[1]   = c1; dec[2]   = c2;
        lbl[0]   = l0; lbl[1]   = l1; lbl[2]   = l2;
    endtask

    task automatic launch();
        res_t r;
        img_str = 0; clr_cnt = 0; pix_in_img = 0; pix_total = 0; resp_cyc = -1;
        exp_correct = 0;
        for (int a = 0; a < NUM_IMG * IMG_PIXELS; a++) begin
            addr_q.push_back(a);
            pix_q.push_back(int'(pix_val(a)));
        end
        for (int i = 0; i < NUM_IMG; i++) begin
            r.idx = i;
            r.cls = (delay[i] >= 0) ? dec[i] : 15;
            r.to  = (delay[i] >= 0) ? 0 : 1;
            res_q.push_back(r);
            if (r.to == 0 && r.cls == lbl[i] && exp_correct < NUM_IMG) exp_correct++;
            last_cls = r.cls;
        end
`ifndef SEQ_SCORE_EN
        exp_correct = 0;
`endif
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 400 && !done; i++) @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_correct_cnt"}, correct_cnt, exp_correct);
        check({tag, "_clr_pulses"}, clr_cnt, NUM_IMG);
        check({tag, "_pix_total"}, pix_total, NUM_IMG * IMG_PIXELS);
        check({tag, "_res_left"}, res_q.size(), 0);
        check({tag, "_addr_left"}, addr_q.size(), 0);
        check({tag, "_res_hold"}, res_class, last_cls);
    endtask

    task automatic flush();
        addr_q.delete(); pix_q.delete(); res_q.delete(); res_cyc_q.delete();
        resp_cyc = -1;
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_cnn_clr", cnn_clr, 0);
        check("rst_correct_cnt", correct_cnt, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        setup(2, 2, 2, 5, 5, 5, 5, 3, 5);
        launch();
        finish_run("basic");

        setup(2, -1, 2, 5, 7, 9, 9, 15, 9);
        launch();
        finish_run("timeout");

        noise_en = 1'b1;
        setup(7, 3, 0, 2, 4, 6, 2, 0, 6);
        launch();
        finish_run("noise_race");
        noise_en = 1'b0;

        setup(1, 1, 1, 3, 3, 3, 3, 3, 3);
        launch();
        for (int i = 0; i < 200 && pix_total < IMG_PIXELS + 2; i++) @(negedge clk);
        check("midrun_reached", pix_total, IMG_PIXELS + 2);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_rd", mem_rd, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_pix_valid", pix_valid, 0);
        check("arst_pix_out", pix_out, 0);
        check("arst_res_class", res_class, 0);
        check("arst_res_idx", res_idx, 0);
        check("arst_correct_cnt", correct_cnt, 0);
        flush();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || mem_rd || cnn_clr) seen++;
        end
        check("no_autostart", seen, 0);

        launch();
        finish_run("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
